// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons, evaluated one neuron per cycle per time step.
// Optional feature: define LIF_REFRACTORY_EN for per-neuron refractory counters.
module lif_neuron_array #(
   parameter int N_INPUTS     = 16,
   parameter int N_NEURONS    = 4,
   parameter int U_WIDTH      = 8,
   parameter int REFRAC_STEPS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_valid,
   input  logic [1:0]           load_sel,
   input  logic [7:0]           load_data,
   input  logic                 step_valid,
   output logic                 step_ready,
   output logic [N_NEURONS-1:0] spike_out,
   output logic                 spike_valid
);

   localparam int IDX_W  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam int EXT_W  = U_WIDTH + 8;
   localparam int W_BITS = N_NEURONS * N_INPUTS;
   localparam logic signed [EXT_W-1:0] ONE   = EXT_W'(1);
   localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'((1 << (U_WIDTH - 1)) - 1);
   localparam logic signed [EXT_W-1:0] U_MIN = EXT_W'(-(1 << (U_WIDTH - 1)));

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   state_t                     state;
   logic [N_INPUTS-1:0]        x;
   logic [W_BITS-1:0]          w;
   logic [6:0]                 threshold;
   logic [2:0]                 shift;
   logic signed [U_WIDTH-1:0]  u [N_NEURONS];
   logic [IDX_W-1:0]           idx;
   logic [N_NEURONS-1:0]       spikes;
`ifdef LIF_REFRACTORY_EN
   logic [3:0]                 refrac [N_NEURONS];
`endif

   logic [N_INPUTS-1:0]        x_next;
   logic [W_BITS-1:0]          w_next;
   logic [N_INPUTS-1:0]        w_sel;
   logic signed [EXT_W-1:0]    syn_sum;
   logic signed [EXT_W-1:0]    u_ext;
   logic signed [EXT_W-1:0]    leak;
   logic signed [EXT_W-1:0]    u_raw;
   logic signed [EXT_W-1:0]    u_sat;
   logic signed [EXT_W-1:0]    thr_ext;
   logic                       fire;

   // Byte-wide shift-in loaders; an 8-bit register is simply replaced.
   if (N_INPUTS > 8) begin : g_x_wide
      assign x_next = {x[N_INPUTS-9:0], load_data};
   end else begin : g_x_byte
      assign x_next = load_data;
   end

   if (W_BITS > 8) begin : g_w_wide
      assign w_next = {w[W_BITS-9:0], load_data};
   end else begin : g_w_byte
      assign w_next = load_data;
   end

   assign step_ready = (state == IDLE) && !load_valid;

   // Datapath for the neuron currently selected by idx: synaptic sum, leak, saturation, threshold.
   always_comb begin
      w_sel   = w[idx*N_INPUTS +: N_INPUTS];
      syn_sum = '0;
      for (int i = 0; i < N_INPUTS; i++) begin
         if (x[i]) begin
            if (w_sel[i]) syn_sum = syn_sum + ONE;
            else          syn_sum = syn_sum - ONE;
         end
      end
      u_ext = EXT_W'(u[idx]);
      if (shift == 3'd0) leak = '0;
      else               leak = u_ext >>> shift;
      u_raw = u_ext - leak + syn_sum;
      if (u_raw > U_MAX)      u_sat = U_MAX;
      else if (u_raw < U_MIN) u_sat = U_MIN;
      else                    u_sat = u_raw;
      thr_ext = EXT_W'({1'b0, threshold});
      fire    = (u_sat >= thr_ext);
   end

   // Control FSM, configuration registers and membrane state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         x           <= '0;
         w           <= '1;
         threshold   <= 7'd5;
         shift       <= 3'd0;
         spikes      <= '0;
         spike_out   <= '0;
         spike_valid <= 1'b0;
         for (int k = 0; k < N_NEURONS; k++) begin
            u[k] <= '0;
`ifdef LIF_REFRACTORY_EN
            refrac[k] <= 4'd0;
`endif
         end
      end else begin
         spike_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  case (load_sel)
                     2'b00:   x         <= x_next;
                     2'b01:   w         <= w_next;
                     2'b10:   threshold <= load_data[6:0];
                     default: shift     <= load_data[2:0];
                  endcase
               end else if (step_valid) begin
                  state  <= EVAL;
                  idx    <= '0;
                  spikes <= '0;
               end
            end
            EVAL: begin
`ifdef LIF_REFRACTORY_EN
               if (refrac[idx] != 4'd0) begin
                  u[idx]      <= '0;
                  refrac[idx] <= refrac[idx] - 4'd1;
               end else if (fire) begin
                  u[idx]      <= '0;
                  spikes[idx] <= 1'b1;
                  refrac[idx] <= 4'(REFRAC_STEPS);
               end else begin
                  u[idx] <= u_sat[U_WIDTH-1:0];
               end
`else
               if (fire) begin
                  u[idx]      <= '0;
                  spikes[idx] <= 1'b1;
               end else begin
                  u[idx] <= u_sat[U_WIDTH-1:0];
               end
`endif
               if (idx == IDX_W'(N_NEURONS - 1)) state <= DONE;
               else                              idx   <= idx + 1'b1;
            end
            DONE: begin
               spike_out   <= spikes;
               spike_valid <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/lif_neuron_array.md
LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameter N_INPUTS, default 16: synapses per neuron; SHALL be 8, 16 or 32.
REQ-002 Parameter N_NEURONS, default 4: neurons in the array; SHALL be 1..16.
REQ-003 Parameter U_WIDTH, default 8: signed membrane-potential width; SHALL be 8..16.
REQ-004 Parameter REFRAC_STEPS, default 2: refractory length in time steps; SHALL be 0..15.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 load_valid  input  1  load_data is written to the target selected by load_sel.
REQ-008 load_sel  input  2  target select: 00 input spikes x, 01 weights w, 10 threshold, 11 leak shift.
REQ-009 load_data  input  8  load payload.
REQ-010 step_valid  input  1  request one time step of integration.
REQ-011 step_ready  output  1  step request is accepted this cycle.
REQ-012 spike_out  output  N_NEURONS  registered spike vector of the last completed step.
REQ-013 spike_valid  output  1  one-cycle pulse; spike_out is updated this cycle.

Function
REQ-014 x SHALL be an N_INPUTS-bit shift register; each x load SHALL perform x <= {x[N_INPUTS-9:0], load_data}.
REQ-015 w SHALL be an N_NEURONS*N_INPUTS-bit shift register loaded the same way; neuron k uses w[k*N_INPUTS +: N_INPUTS].
REQ-016 A threshold load SHALL set threshold <= load_data[6:0], zero-extended; a shift load SHALL set shift <= load_data[2:0].
REQ-017 Loads SHALL take effect only in IDLE; load_valid in EVAL or DONE SHALL be ignored.
REQ-018 FSM states: IDLE, EVAL, DONE.
- IDLE -> EVAL on step accept.
- EVAL lasts exactly N_NEURONS cycles, one neuron per cycle, index 0 first.
- EVAL -> DONE after the last neuron.
- DONE -> IDLE after one cycle.
REQ-019 step_ready SHALL equal (state==IDLE && !load_valid); a simultaneous load therefore wins and the step waits.
REQ-020 Synaptic sum for neuron k SHALL be the sum over i of x[i] ? (w bit ? +1 : -1) : 0.
REQ-021 Leak:
- u_next = u - (u >>> shift) + sum, with arithmetic shift.
- shift==0 SHALL mean no leak, so u_next = u + sum.
REQ-022 u_next SHALL saturate to [-2^(U_WIDTH-1), 2^(U_WIDTH-1)-1]; it SHALL never wrap around.
REQ-023 If u_next >= threshold (signed compare), the neuron SHALL spike, and u SHALL be set to 0.
REQ-024 Otherwise u SHALL be set to u_next with no spike.
REQ-025 In DONE, spike_out SHALL take the spikes collected during EVAL and spike_valid SHALL be 1.
- spike_valid SHALL rise N_NEURONS+1 cycles after the accepting edge.
- spike_out SHALL hold its value until the next DONE.
REQ-026 x, w, threshold and shift SHALL persist across steps until reloaded.

Reset
REQ-027 Reset SHALL apply in any state, including mid-EVAL, and SHALL leave the block as follows:
- state IDLE, all u = 0;
- x = 0, w = all ones (+1), threshold = 5, shift = 0;
- spike_out = 0, spike_valid = 0, refractory counters = 0.
REQ-028 A step interrupted by reset SHALL produce no spike_valid pulse.

Configuration
REQ-029 Macro LIF_REFRACTORY_EN defined: each neuron SHALL have a 4-bit counter.
- On a spike the counter SHALL be loaded with REFRAC_STEPS.
- While the counter is nonzero, that neuron's evaluation SHALL hold u = 0, emit no spike and decrement the counter.
REQ-030 Macro LIF_REFRACTORY_EN undefined: no counters SHALL exist, and neurons SHALL integrate on the step immediately after a spike.

Verification
REQ-031 Configuration N_INPUTS=16, N_NEURONS=4, REFRAC_STEPS=2 for all scenarios below.
REQ-032 Reset, x=0xFFFF, default w, threshold 5, one step -> spike_valid 5 cycles after accept; spike_out=4'b1111; all u=0.
REQ-033 x=0x0003, w all +1, threshold 5, shift 0, three steps -> spike_out 0, 0, 4'b1111; u goes 2, 4, then 0.
REQ-034 x=0x000F, shift 1, threshold 5 -> u=4 on step 1, spike on step 2 (4-2+4=6).
REQ-035 Neuron 0 weights all 0 (-1), x=0xFFFF, 20 steps -> neuron 0 u saturates at -128 and never spikes; neurons 1..3 spike every step.
REQ-036 LIF_REFRACTORY_EN with x=0xFFFF -> each neuron spike pattern 1,0,0,1.
- Without the macro, the pattern SHALL be 1,1,1,1.
REQ-037 Reset asserted 2 cycles into EVAL -> no spike_valid; step_ready=1 the cycle after reset deasserts; all u=0.
REQ-038 load_valid and step_valid both high in IDLE -> load applied; step_ready=0; step accepted the next cycle once load_valid drops.
